alu_flag_ctrl: RTL and testbench
================================

// Module: alu_flag_ctrl
// PURPOSE
//  Consumer side of the ALU result/flag interface. Holds the architectural NZCV register,
//  written from ALU n/z/c/o flags on flag-setting ops; evaluates 4-bit condition codes for
//  branch/predication requests. Scoreboards in-flight flag writers and stalls a request
//  until its flags are final. Sits between the ALU output and the branch/issue stage.
// PARAMETERS
//  PEND_W   2    width of in-flight flag-writer counter; max outstanding = 2**PEND_W-1
//  NZCV_RST 4'h0 reset value of NZCV register, {N,Z,C,V}
// PORTS
//  clk         in   1       clock, rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  setf_issue  in   1       a flag-setting ALU op was issued this cycle (counter +1)
//  setf_ready  out  1       counter not full; setf_issue only legal when 1
//  alu_wr      in   1       ALU flags valid and flag-setting this cycle (counter -1)
//  alu_n/z/c/o in   1 each  ALU flags, stored as delivered (c = raw carry/borrow bit)
//  cond_valid  in   1       condition request valid
//  cond        in   4       ARM-style condition code
//  cond_ready  out  1       request accepted when cond_valid&cond_ready
//  resp_valid  out  1       one-cycle pulse: evaluation result valid
//  resp_pass   out  1       condition true (valid only with resp_valid)
//  nzcv        out  4       current NZCV register
//  err         out  1       sticky: alu_wr with counter 0, or setf_issue while full
// BEHAVIOUR
//  Reset: nzcv=NZCV_RST, counter=0, state IDLE, resp_valid=0, resp_pass=0, err=0,
//   cond_ready=1, setf_ready=1. Reset mid-request drops it; no response is produced.
//  NZCV: on alu_wr, nzcv<={n,z,c,o} at the clock edge (also when counter is 0; err set then).
//  Counter: issue&wr same cycle -> unchanged; issue only -> +1; wr only -> -1.
//   wr at 0 -> stays 0, err=1. issue while full -> ignored, err=1. No wrap either way.
//  FSM (cond_ready=1 only in IDLE; pass computed by cond_eval):
//   IDLE: on cond_valid, capture cond. If counter==0 and !alu_wr: evaluate current nzcv,
//    resp_valid=1 next cycle, stay IDLE (1-cycle latency, back-to-back each cycle).
//    Else -> WAIT.
//   WAIT: when counter==0: evaluate nzcv, pulse response next cycle -> IDLE.
//    Flags written in the cycle the counter hits 0 are visible the cycle after.
//  Conditions: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V;
//   8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V);
//   E AL 1; F NV 0.
// CONFIGURATION
//  FLAG_FWD_EN defined: in IDLE or WAIT, if alu_wr and counter==1 and !setf_issue, the
//   incoming {n,z,c,o} are forwarded to cond_eval and the response pulses next cycle
//   (saves one cycle). Undefined: no bypass; evaluation only reads registered nzcv.
// STRUCTURE
//  Package alu_pkg: cond code localparams (COND_EQ..COND_NV), NZCV bit indices
//   (N=3,Z=2,C=1,V=0), aluOp encodings shared with the ALU (NOP,ADD,SUB,SHL).
//  Sub-module cond_eval: combinational (nzcv[3:0], cond[3:0]) -> pass.
//  Top: counter, NZCV register, 2-state FSM, response register.
// TESTING
//  1 Reset nzcv=0; cond=E, counter 0 -> resp_valid next cycle, pass=1; cond=F -> pass=0.
//  2 alu_wr {n,z,c,o}=0100; then cond=0 -> pass=1; cond=1 -> pass=0; nzcv reads 4'b0100.
//  3 setf_issue x2, cond=0 -> cond_ready 0 until two alu_wr retire; response 1 cycle after
//    counter==0 (2 cycles after last wr without FLAG_FWD_EN, 1 with).
//  4 Fill counter to 3 -> setf_ready=0; issue again -> counter stays 3, err=1.
//  5 alu_wr at counter 0 -> nzcv updated, counter stays 0, err=1 until reset.
//  6 nzcv=1001 (N=1,V=1): GE pass=1, LT 0, GT 1, LE 0; assert reset_n in WAIT -> no resp.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU and its flag consumer.
//  - condition code encodings (ARM style, COND_EQ..COND_NV)
//  - NZCV bit positions inside the 4-bit flag register {N,Z,C,V}
//  - ALU operation encodings used by the ALU issue logic
//  - control FSM state type for alu_flag_ctrl
package alu_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    ALU_NOP = 2'd0,
    ALU_ADD = 2'd1,
    ALU_SUB = 2'd2,
    ALU_SHL = 2'd3
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/alu_flag_ctrl_cond_eval.sv
// cond_eval: purely combinational condition-code evaluator.
// Ports:
//  nzcv  in  4  flag vector {N,Z,C,V}
//  cond  in  4  ARM-style condition code
//  pass  out 1  condition holds for the given flags
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] nzcv,
  input  logic [3:0] cond,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[NZCV_N];
  assign z = nzcv[NZCV_Z];
  assign c = nzcv[NZCV_C];
  assign v = nzcv[NZCV_V];

  // Decode the condition against the individual flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_ctrl.sv
// alu_flag_ctrl: holds the architectural NZCV register, tracks in-flight
// flag-setting ALU ops and answers condition requests once flags are final.
// Optional feature: FLAG_FWD_EN (when defined, the last retiring flag write is
// bypassed straight into the evaluator, saving one cycle of latency).
// Ports:
//  clk, reset_n          clock (rising edge), async active-low reset
//  setf_issue/setf_ready flag-setting op issued / counter not full
//  alu_wr, alu_n/z/c/o   ALU flag write and the flag values
//  cond_valid/cond/cond_ready  condition request handshake
//  resp_valid/resp_pass  one-cycle result pulse and result
//  nzcv                  current flag register
//  err                   sticky counter under/overflow error
module alu_flag_ctrl
  import alu_pkg::*;
#(
  parameter int         PEND_W   = 2,
  parameter logic [3:0] NZCV_RST = 4'h0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       setf_issue,
  output logic       setf_ready,
  input  logic       alu_wr,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_o,
  input  logic       cond_valid,
  input  logic [3:0] cond,
  output logic       cond_ready,
  output logic       resp_valid,
  output logic       resp_pass,
  output logic [3:0] nzcv,
  output logic       err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pend;
  ctrl_state_e       state;
  logic [3:0]        cond_q;
  logic [3:0]        eval_cond;
  logic [3:0]        eval_nzcv;
  logic              eval_pass;
  logic              pend_full;
  logic              pend_zero;
  logic              fwd_hit;

  assign pend_full  = (pend == PEND_MAX);
  assign pend_zero  = (pend == '0);
  assign setf_ready = !pend_full;
  assign cond_ready = (state == ST_IDLE);

`ifdef FLAG_FWD_EN
  // The write that retires the last outstanding writer carries final flags.
  assign fwd_hit = alu_wr && (pend == PEND_ONE) && !setf_issue;
`else
  assign fwd_hit = 1'b0;
`endif

  // In IDLE the request is evaluated the cycle it arrives, so use the live cond.
  assign eval_cond = (state == ST_IDLE) ? cond : cond_q;
  assign eval_nzcv = fwd_hit ? {alu_n, alu_z, alu_c, alu_o} : nzcv;

  cond_eval u_cond_eval (
    .nzcv (eval_nzcv),
    .cond (eval_cond),
    .pass (eval_pass)
  );

  // Flag register: every ALU write lands, even an erroneous one at counter 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nzcv <= NZCV_RST;
    end else if (alu_wr) begin
      nzcv <= {alu_n, alu_z, alu_c, alu_o};
    end
  end

  // In-flight writer counter saturates at both ends; an issue and a retire in
  // the same cycle cancel out. Illegal saturating events latch err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
      err  <= 1'b0;
    end else begin
      case ({setf_issue, alu_wr})
        2'b10: begin
          if (pend_full) err  <= 1'b1;
          else           pend <= pend + PEND_ONE;
        end
        2'b01: begin
          if (pend_zero) err  <= 1'b1;
          else           pend <= pend - PEND_ONE;
        end
        default: ;
      endcase
    end
  end

  // Request FSM: answer immediately when no writer is outstanding (and no
  // write is landing this cycle), otherwise park in WAIT until the counter
  // drains. The registered nzcv is already final the cycle after it drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cond_q     <= 4'h0;
      resp_valid <= 1'b0;
      resp_pass  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cond_valid) begin
            cond_q <= cond;
            if ((pend_zero && !alu_wr) || fwd_hit) begin
              resp_valid <= 1'b1;
              resp_pass  <= eval_pass;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (pend_zero || fwd_hit) begin
            resp_valid <= 1'b1;
            resp_pass  <= eval_pass;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flag_ctrl.sv
// tb_alu_flag_ctrl: directed-vector bench for alu_flag_ctrl with
// hand-computed expectations.
module tb_alu_flag_ctrl;

  logic       clk;
  logic       reset_n;
  logic       setf_issue;
  logic       setf_ready;
  logic       alu_wr;
  logic       alu_n, alu_z, alu_c, alu_o;
  logic       cond_valid;
  logic [3:0] cond;
  logic       cond_ready;
  logic       resp_valid;
  logic       resp_pass;
  logic [3:0] nzcv;
  logic       err;

  int total = 0;
  int bad   = 0;

  // Expected pass per condition code (bit i = cond i) for three flag sets.
  logic [15:0] exp_1001;
  logic [15:0] exp_0110;
  logic [15:0] exp_0010;

  alu_flag_ctrl #(.PEND_W(2), .NZCV_RST(4'h0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .setf_issue (setf_issue),
    .setf_ready (setf_ready),
    .alu_wr     (alu_wr),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_o      (alu_o),
    .cond_valid (cond_valid),
    .cond       (cond),
    .cond_ready (cond_ready),
    .resp_valid (resp_valid),
    .resp_pass  (resp_pass),
    .nzcv       (nzcv),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then step to 1 time unit after the next edge.
  task automatic applyStimulus(input logic iss, input logic wr, input logic [3:0] flags,
                               input logic cv, input logic [3:0] c);
    setf_issue = iss;
    alu_wr     = wr;
    {alu_n, alu_z, alu_c, alu_o} = flags;
    cond_valid = cv;
    cond       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    reset_n = 1'b0;
    #2;
    checkOutput("rst_nzcv", nzcv, 4'h0);
    checkOutput("rst_err", {3'b0, err}, 4'h0);
    checkOutput("rst_resp_valid", {3'b0, resp_valid}, 4'h0);
    checkOutput("rst_cond_ready", {3'b0, cond_ready}, 4'h1);
    checkOutput("rst_setf_ready", {3'b0, setf_ready}, 4'h1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Load nzcv through a legal issue/write pair, then sweep all 16 conditions
  // back-to-back, each answered in the following cycle.
  task automatic sweepConds(input logic [3:0] flags, input logic [15:0] exp);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, flags, 1'b0, 4'h0);
    checkOutput("sweep_nzcv", nzcv, flags);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'(i));
      checkOutput($sformatf("sweep_%0h_valid_c%0h", flags, i), {3'b0, resp_valid}, 4'h1);
      checkOutput($sformatf("sweep_%0h_pass_c%0h", flags, i), {3'b0, resp_pass}, {3'b0, exp[i]});
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  initial begin
    exp_1001 = 16'h565A;
    exp_0110 = 16'h66A5;
    exp_0010 = 16'h55A6;
    reset_n    = 1'b0;
    setf_issue = 1'b0;
    alu_wr     = 1'b0;
    {alu_n, alu_z, alu_c, alu_o} = 4'h0;
    cond_valid = 1'b0;
    cond       = 4'h0;
    doReset();

    // 1: always / never with no writers outstanding
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'hE);
    checkOutput("t1_al_valid", {3'b0, resp_valid}, 4'h1);
    checkOutput("t1_al_pass", {3'b0, resp_pass}, 4'h1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'hF);
    checkOutput("t1_nv_valid", {3'b0, resp_valid}, 4'h1);
    checkOutput("t1_nv_pass", {3'b0, resp_pass}, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("t1_idle_valid", {3'b0, resp_valid}, 4'h0);

    // 2: write Z=1, then EQ / NE
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0, 4'h0);
    checkOutput("t2_nzcv", nzcv, 4'b0100);
    checkOutput("t2_err", {3'b0, err}, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'h0);
    checkOutput("t2_eq_pass", {3'b0, resp_pass}, 4'h1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'h1);
    checkOutput("t2_ne_valid", {3'b0, resp_valid}, 4'h1);
    checkOutput("t2_ne_pass", {3'b0, resp_pass}, 4'h0);

    // 3: request stalls behind two in-flight writers
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'h0);
    checkOutput("t3_stall_ready", {3'b0, cond_ready}, 4'h0);
    checkOutput("t3_stall_valid", {3'b0, resp_valid}, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("t3_hold_ready", {3'b0, cond_ready}, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 4'h0);
    checkOutput("t3_wr1_valid", {3'b0, resp_valid}, 4'h0);
    checkOutput("t3_wr1_nzcv", nzcv, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0, 4'h0);
`ifdef FLAG_FWD_EN
    checkOutput("t3_fwd_valid", {3'b0, resp_valid}, 4'h1);
    checkOutput("t3_fwd_pass", {3'b0, resp_pass}, 4'h1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("t3_after_valid", {3'b0, resp_valid}, 4'h0);
    checkOutput("t3_after_ready", {3'b0, cond_ready}, 4'h1);
`else
    checkOutput("t3_wr2_valid", {3'b0, resp_valid}, 4'h0);
    checkOutput("t3_wr2_ready", {3'b0, cond_ready}, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("t3_resp_valid", {3'b0, resp_valid}, 4'h1);
    checkOutput("t3_resp_pass", {3'b0, resp_pass}, 4'h1);
    checkOutput("t3_resp_ready", {3'b0, cond_ready}, 4'h1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("t3_after_valid", {3'b0, resp_valid}, 4'h0);
`endif

    // 4: fill to 3, overflow attempt, drain
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("t4_ready_1", {3'b0, setf_ready}, 4'h1);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("t4_full_ready", {3'b0, setf_ready}, 4'h0);
    checkOutput("t4_full_err", {3'b0, err}, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("t4_ovf_ready", {3'b0, setf_ready}, 4'h0);
    checkOutput("t4_ovf_err", {3'b0, err}, 4'h1);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
    checkOutput("t4_drain1_ready", {3'b0, setf_ready}, 4'h1);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
    checkOutput("t4_drain_err", {3'b0, err}, 4'h1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'hE);
    checkOutput("t4_empty_valid", {3'b0, resp_valid}, 4'h1);
    doReset();

    // 5: write with nothing outstanding
    applyStimulus(1'b0, 1'b1, 4'b1010, 1'b0, 4'h0);
    checkOutput("t5_nzcv", nzcv, 4'b1010);
    checkOutput("t5_err", {3'b0, err}, 4'h1);
    checkOutput("t5_setf_ready", {3'b0, setf_ready}, 4'h1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'h4);
    checkOutput("t5_mi_valid", {3'b0, resp_valid}, 4'h1);
    checkOutput("t5_mi_pass", {3'b0, resp_pass}, 4'h1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("t5_err_sticky", {3'b0, err}, 4'h1);
    doReset();

    // 6: full condition sweeps, then reset while waiting
    sweepConds(4'b1001, exp_1001);
    sweepConds(4'b0110, exp_0110);
    sweepConds(4'b0010, exp_0010);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'hE);
    checkOutput("t6_wait_ready", {3'b0, cond_ready}, 4'h0);
    doReset();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("t6_norsp_1", {3'b0, resp_valid}, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    checkOutput("t6_norsp_2", {3'b0, resp_valid}, 4'h0);
    checkOutput("t6_ready", {3'b0, cond_ready}, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
